// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its output skid buffer.
package fifo_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry valid/ready output buffer with a single-cycle clear; head entry drives the stream.
module stream_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        count
);
    import fifo_pkg::*;

    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [1:0]        cnt;
    logic              push;
    logic              pop;

    assign m_valid = (cnt != 2'd0);
    assign m_data  = d0;
    assign count   = cnt;
    assign pop     = m_valid && m_ready;
    assign s_ready = (cnt != 2'(BUF_DEPTH)) || pop;
    assign push    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            d0  <= '0;
            d1  <= '0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) d0 <= s_data;
                    else             d1 <= s_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged: new word joins behind whatever remains
                    if (cnt == 2'd1) begin
                        d0 <= s_data;
                    end else begin
                        d0 <= d1;
                        d1 <= s_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads an upstream FIFO into a valid/ready stream with credit-limited reads and a flush sequence.
// Optional macro FIFO_STREAM_READER_CNT_EN adds a 16-bit completed-transfer counter (xfer_cnt).
module fifo_stream_reader #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
`ifdef FIFO_STREAM_READER_CNT_EN
    output logic [15:0]       xfer_cnt,
`endif
    output logic              busy
);
    import fifo_pkg::*;

    rd_state_t         state;
    rd_state_t         state_next;
    logic              rd_pend;
    logic              in_run;
    logic              pop;
    logic              push;
    logic              buf_ready;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic [1:0]        buf_count;
    logic [2:0]        occ;

    assign in_run  = (state == RUN) && !rst;
    assign m_valid = buf_valid && in_run;
    assign m_data  = rst ? '0 : buf_data;
    assign pop     = m_valid && m_ready;
    assign busy    = (state != RUN) && !rst;

    // buffered + in-flight - leaving this cycle; pop implies buf_count >= 1, so no underflow
    assign occ       = {1'b0, buf_count} + {2'b0, rd_pend} - {2'b0, pop};
    assign fifo_r_en = in_run && !flush && !fifo_empty && (occ < 3'(BUF_DEPTH));
    assign push      = rd_pend && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_next;
            rd_pend <= fifo_r_en;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush)    state_next = DRAIN;
            DRAIN:   if (!rd_pend) state_next = CLEAR;
            CLEAR:   if (!flush)   state_next = RUN;
            default:               state_next = RUN;
        endcase
    end

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == CLEAR),
        .s_valid (push),
        .s_ready (buf_ready),
        .s_data  (fifo_data),
        .m_valid (buf_valid),
        .m_ready (m_ready && in_run),
        .m_data  (buf_data),
        .count   (buf_count)
    );

`ifdef FIFO_STREAM_READER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state_next == CLEAR && state != CLEAR)) begin
            xfer_cnt <= 16'd0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule
